// File: rtl/putramaddr.sv
// Result-RAM write address generator: turns a raster stream of accepted pixels
// into RAM writes over a TW x TH window at BASE, with a fixed row stride.
module putramaddr #(
  parameter int unsigned DW     = 8,
  parameter int unsigned AW     = 14,
  parameter int unsigned STRIDE = 128
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] BASE,
  input  logic [4:0]    TW,
  input  logic [4:0]    TH,
  input  logic          res_valid,
  input  logic [DW-1:0] res_data,
  output logic          res_ready,
  output logic          we,
  output logic [AW-1:0] waddr,
  output logic [DW-1:0] wdata,
  output logic          rowend,
  output logic          busy,
  output logic          done
);

  localparam logic [AW-1:0] StrideW = AW'(STRIDE);

  typedef enum logic [1:0] {StIdle, StLoad, StWrite, StFin} state_e;

  state_e        state_q;
  logic [4:0]    tw_q, th_q, col_q, row_q;
  logic [AW-1:0] row_base_q;
  logic          accept, col_last, row_last;

  assign res_ready = (state_q == StWrite);
  assign busy      = (state_q != StIdle);
  assign accept    = res_valid && res_ready;
  // tw_q/th_q are non-zero whenever these are used (WRITE is only entered then)
  assign col_last  = (col_q == tw_q - 5'd1);
  assign row_last  = (row_q == th_q - 5'd1);
  assign rowend    = accept && col_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      tw_q       <= '0;
      th_q       <= '0;
      col_q      <= '0;
      row_q      <= '0;
      row_base_q <= '0;
      we         <= 1'b0;
      waddr      <= '0;
      wdata      <= '0;
      done       <= 1'b0;
    end else begin
      we   <= 1'b0;
      done <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) state_q <= StLoad;
        end
        StLoad: begin
          tw_q       <= TW;
          th_q       <= TH;
          col_q      <= '0;
          row_q      <= '0;
          row_base_q <= BASE;
          if (TW == 5'd0 || TH == 5'd0) begin
            state_q <= StFin;
            done    <= 1'b1;
          end else begin
            state_q <= StWrite;
          end
        end
        StWrite: begin
          if (accept) begin
            we    <= 1'b1;
            waddr <= row_base_q + AW'(col_q);
            wdata <= res_data;
            if (col_last) begin
              col_q      <= '0;
              row_q      <= row_q + 5'd1;
              row_base_q <= row_base_q + StrideW;
              if (row_last) begin
                state_q <= StFin;
                done    <= 1'b1;
              end
            end else begin
              col_q <= col_q + 5'd1;
            end
          end
        end
        StFin: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: doc/putramaddr.md
Name: putramaddr

Overview:
Write-side counterpart of the ROM read-address scanner. It accepts a raster stream of processed pixels over a valid/ready handshake and turns each one into a result-RAM write: write enable, address and data. Pixels arrive row-major over a TW x TH output window placed at a programmable base address in a fixed-stride RAM. It signals when the window is finished so the top-level controller can advance.

Parameters:
DW, 8, pixel data width
AW, 14, RAM address width
STRIDE, 128, RAM words per output row; must be ≥ TW

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
start  input  1  one-cycle pulse; latches BASE/TW/TH and begins a window
BASE  input  AW  RAM address of window pixel (0,0)
TW  input  5  window width in pixels, 0..31
TH  input  5  window height in pixels, 0..31
res_valid  input  1  upstream pixel valid
res_data  input  DW  upstream pixel value
res_ready  output  1  block can accept a pixel this cycle
we  output  1  RAM write enable, one cycle per pixel
waddr  output  AW  RAM write address
wdata  output  DW  RAM write data
rowend  output  1  the pixel accepted this cycle is the last of its row
busy  output  1  window in progress (state ≠ IDLE)
done  output  1  one-cycle pulse when the window is complete

Behaviour:
- Reset (asynchronous, immediate): state=IDLE. res_ready, we, rowend, busy, done = 0. waddr=0, wdata=0. col, row, row_base = 0.
- States:
  - IDLE: start → LOAD; otherwise stay.
  - LOAD (1 cycle): latch BASE/TW/TH; col=0, row=0, row_base=BASE. If TW==0 or TH==0 → FIN, else → WRITE.
  - WRITE: run until the last pixel is accepted, then → FIN.
  - FIN (1 cycle): done=1, then → IDLE.
- res_ready = 1 only in WRITE. A pixel is accepted when res_valid && res_ready.
- Accepted pixel timing: the following cycle has we=1, waddr=row_base+col (value at acceptance, truncated to AW bits), wdata=res_data. When nothing is accepted, we=0 and waddr/wdata hold their last values.
- Counters update on each accept:
  - If col==TW-1: col=0, row=row+1, row_base=row_base+STRIDE (mod 2^AW). rowend=1 combinationally in that accept cycle.
  - Otherwise: col=col+1.
- Last accept (col==TW-1 and row==TH-1): state → FIN. The final write (we=1) and done=1 therefore fall in the same cycle.
- Back-pressure: only upstream stalls; res_valid low in WRITE inserts bubbles with no write and no counter change.
- Addresses are computed incrementally only; no multiplier.
- start outside IDLE is ignored. BASE/TW/TH changes after LOAD have no effect on the window in progress.
- Reset mid-window aborts immediately. No further we; done is not asserted.
- Total writes per window = TW*TH exactly. Each address is written once, in raster order.

Test Plan:
- BASE=0x0105, TW=3, TH=2, res_valid held high → writes to 0x105, 0x106, 0x107, 0x185, 0x186, 0x187 on 6 consecutive cycles. rowend on accepts 3 and 6. done coincides with the 6th we. busy falls the next cycle.
- Same window with res_valid toggling 1,0,1,0,… → same 6 addresses and data in order. we only on the cycle after each accept. done after the 6th write.
- TW=0, TH=5, start → busy for 2 cycles (LOAD, FIN), done pulses once, we never asserted.
- BASE=0x3FFE, TW=4, TH=1 → addresses 0x3FFE, 0x3FFF, 0x0000, 0x0001 (wrap-around), done once.
- start pulsed again during WRITE with different BASE → ignored; original address sequence completes unchanged.
- rst asserted after 3 of 9 accepts (TW=3, TH=3) → all outputs 0 immediately, state IDLE, no done. A new start then writes the full 9-pixel window from (0,0).
